// File: rtl/adc_capture_ctrl.sv
// AD9220 acquisition sequencer: pre-trigger ring, level trigger, post capture, valid/ready readout.
// Optional auto-trigger after TIMEOUT samples in WAIT_TRIG: define ADC_CAP_AUTOTRIG_EN.
module adc_capture_ctrl #(
   parameter int DW      = 13,
   parameter int AW      = 10,
   parameter int TIMEOUT = 65536
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [DW-1:0] samp_data,
   input  logic          samp_valid,
   input  logic          arm,
   input  logic          abort,
   input  logic [AW-1:0] pre_len,
   input  logic [AW-1:0] post_len,
   input  logic [11:0]   trig_level,
   output logic          busy,
   output logic          triggered,
   output logic          done,
   output logic          ovr_seen,
   output logic [DW-1:0] rd_data,
   output logic          rd_valid,
   input  logic          rd_ready,
   output logic          rd_last
);

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_PREFILL = 3'd1;
   localparam logic [2:0] S_WAIT    = 3'd2;
   localparam logic [2:0] S_POST    = 3'd3;
   localparam logic [2:0] S_READ    = 3'd4;

   localparam logic [AW:0] DEPTH = {1'b1, {AW{1'b0}}};

   function automatic logic [AW-1:0] post_fix(input logic [AW-1:0] p);
      return (p == '0) ? {{(AW-1){1'b0}}, 1'b1} : p;
   endfunction

   // Saturate pre so that the whole record fits in the ring.
   function automatic logic [AW-1:0] clamp_pre(input logic [AW-1:0] pre, input logic [AW-1:0] post);
      logic [AW:0] sum;
      logic [AW:0] lim;
      sum = {1'b0, pre} + {1'b0, post};
      lim = DEPTH - {1'b0, post};
      return (sum > DEPTH) ? lim[AW-1:0] : pre;
   endfunction

   logic [2:0]    state;
   logic [AW-1:0] pre_q, post_q, wp, rd_ptr;
   logic [11:0]   lvl_q, prev_code;
   logic          prev_vld;
   logic [AW:0]   cnt, cnt_inc, rem;
   logic [AW-1:0] post_n, pre_n;
   logic [11:0]   cur_code;
   logic          wr_en, lvl_hit, force_hit, trig_fire;
   logic          pop, out_free, issue, skid_ld;
   logic [1:0]    occ;

   logic [DW-1:0] mem [0:(1<<AW)-1];
   logic [DW-1:0] rdat_p1, skid_data;
   logic          vld_p1, last_p1, skid_vld, skid_last;

`ifdef ADC_CAP_AUTOTRIG_EN
   localparam int TW = $clog2(TIMEOUT + 1);
   logic [TW-1:0] tcnt;
   logic [TW:0]   tcnt_inc;
   assign tcnt_inc  = {1'b0, tcnt} + 1'b1;
   assign force_hit = (tcnt_inc == (TW+1)'(TIMEOUT));
`else
   assign force_hit = 1'b0;
`endif

   assign busy     = (state != S_IDLE);
   assign post_n   = post_fix(post_len);
   assign pre_n    = clamp_pre(pre_len, post_n);
   assign cur_code = samp_data[11:0];
   assign cnt_inc  = cnt + 1'b1;
   assign wr_en    = samp_valid && !abort &&
                     (state == S_PREFILL || state == S_WAIT || state == S_POST);
   assign lvl_hit  = prev_vld && (prev_code < lvl_q) && (cur_code >= lvl_q);
   assign trig_fire = wr_en && (state == S_WAIT) && (lvl_hit || force_hit);

   // Readout credit: output register plus skid hold two beats, including one in flight from RAM.
   assign pop      = rd_valid && rd_ready;
   assign out_free = !rd_valid || rd_ready;
   assign occ      = {1'b0, rd_valid} + {1'b0, skid_vld} + {1'b0, vld_p1};
   assign issue    = (state == S_READ) && !abort && (rem != '0) &&
                     (occ <= (pop ? 2'd2 : 2'd1));
   assign skid_ld  = vld_p1 && (!out_free || skid_vld);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= S_IDLE;
         pre_q     <= '0;
         post_q    <= '0;
         lvl_q     <= '0;
         wp        <= '0;
         rd_ptr    <= '0;
         cnt       <= '0;
         rem       <= '0;
         prev_vld  <= 1'b0;
         triggered <= 1'b0;
         done      <= 1'b0;
         ovr_seen  <= 1'b0;
         rd_data   <= '0;
         rd_valid  <= 1'b0;
         rd_last   <= 1'b0;
         vld_p1    <= 1'b0;
         last_p1   <= 1'b0;
         skid_vld  <= 1'b0;
         skid_last <= 1'b0;
`ifdef ADC_CAP_AUTOTRIG_EN
         tcnt      <= '0;
`endif
      end else begin
         done <= 1'b0;
         if (abort) begin
            state    <= S_IDLE;
            rd_valid <= 1'b0;
            rd_last  <= 1'b0;
            vld_p1   <= 1'b0;
            last_p1  <= 1'b0;
            skid_vld <= 1'b0;
         end else begin
            case (state)
               S_IDLE: begin
                  if (arm) begin
                     pre_q     <= pre_n;
                     post_q    <= post_n;
                     lvl_q     <= trig_level;
                     wp        <= '0;
                     cnt       <= '0;
                     prev_vld  <= 1'b0;
                     triggered <= 1'b0;
                     ovr_seen  <= 1'b0;
                     state     <= (pre_n == '0) ? S_WAIT : S_PREFILL;
`ifdef ADC_CAP_AUTOTRIG_EN
                     tcnt      <= '0;
`endif
                  end
               end
               S_PREFILL: begin
                  if (samp_valid) begin
                     cnt <= cnt_inc;
                     if (cnt_inc == {1'b0, pre_q}) begin
                        state <= S_WAIT;
`ifdef ADC_CAP_AUTOTRIG_EN
                        tcnt  <= '0;
`endif
                     end
                  end
               end
               S_WAIT: begin
`ifdef ADC_CAP_AUTOTRIG_EN
                  if (samp_valid) tcnt <= tcnt_inc[TW-1:0];
`endif
                  if (trig_fire) begin
                     triggered <= lvl_hit;
                     rd_ptr    <= wp - pre_q;
                     rem       <= {1'b0, pre_q} + {1'b0, post_q};
                     cnt       <= {{AW{1'b0}}, 1'b1};
                     if (post_q == {{(AW-1){1'b0}}, 1'b1}) begin
                        state <= S_READ;
                        done  <= 1'b1;
                     end else begin
                        state <= S_POST;
                     end
                  end
               end
               S_POST: begin
                  if (samp_valid) begin
                     cnt <= cnt_inc;
                     if (cnt_inc == {1'b0, post_q}) begin
                        state <= S_READ;
                        done  <= 1'b1;
                     end
                  end
               end
               S_READ: begin
                  if (pop && rd_last) state <= S_IDLE;
               end
               default: state <= S_IDLE;
            endcase

            if (wr_en) begin
               wp       <= wp + 1'b1;
               prev_vld <= 1'b1;
               if (samp_data[12]) ovr_seen <= 1'b1;
            end

            // p0 -> p1: RAM read issued, data returns next cycle.
            vld_p1  <= issue;
            last_p1 <= issue && (rem == {{AW{1'b0}}, 1'b1});
            if (issue) begin
               rd_ptr <= rd_ptr + 1'b1;
               rem    <= rem - 1'b1;
            end

            // p1 -> output: skid drains first so beat order is preserved.
            if (out_free) begin
               if (skid_vld) begin
                  rd_data   <= skid_data;
                  rd_valid  <= 1'b1;
                  rd_last   <= skid_last;
                  skid_vld  <= vld_p1;
                  skid_last <= last_p1;
               end else if (vld_p1) begin
                  rd_data  <= rdat_p1;
                  rd_valid <= 1'b1;
                  rd_last  <= last_p1;
               end else begin
                  rd_valid <= 1'b0;
                  rd_last  <= 1'b0;
               end
            end else if (vld_p1) begin
               skid_vld  <= 1'b1;
               skid_last <= last_p1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wp]   <= samp_data;
         prev_code <= cur_code;
      end
      if (issue)   rdat_p1   <= mem[rd_ptr];
      if (skid_ld) skid_data <= rdat_p1;
   end

endmodule

// File: tb/tb_adc_capture_ctrl.sv
// Randomized/directed bench for adc_capture_ctrl against a record-level reference model.
`timescale 1ns/1ps
module tb_adc_capture_ctrl;
   localparam int DW = 13;
   localparam int AW = 10;
`ifdef ADC_CAP_AUTOTRIG_EN
   localparam int TMO  = 16;
   localparam bit AUTO = 1'b1;
`else
   localparam int TMO  = 65536;
   localparam bit AUTO = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [DW-1:0] samp_data = '0;
   logic          samp_valid = 1'b0;
   logic          arm = 1'b0;
   logic          abort = 1'b0;
   logic [AW-1:0] pre_len = '0;
   logic [AW-1:0] post_len = '0;
   logic [11:0]   trig_level = '0;
   logic          busy, triggered, done, ovr_seen, rd_valid, rd_last;
   logic [DW-1:0] rd_data;
   logic          rd_ready = 1'b0;

   int total = 0;
   int bad = 0;
   int done_cnt = 0;
   int stim[$];
   int expq[$];

   always #5 clk = ~clk;
   always @(posedge clk) if (done) done_cnt++;

   adc_capture_ctrl #(.DW(DW), .AW(AW), .TIMEOUT(TMO)) dut (
      .clk(clk), .rst(rst), .samp_data(samp_data), .samp_valid(samp_valid),
      .arm(arm), .abort(abort), .pre_len(pre_len), .post_len(post_len),
      .trig_level(trig_level), .busy(busy), .triggered(triggered), .done(done),
      .ovr_seen(ovr_seen), .rd_data(rd_data), .rd_valid(rd_valid),
      .rd_ready(rd_ready), .rd_last(rd_last)
   );

   initial begin
      #3ms;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Reference: scan the sample stream for the trigger, slice the record out of it.
   task automatic model(input int pre_in, input int post_in, input int lvl,
                        output int t, output int post_e, output bit hit, output bit ovr);
      int pre_e;
      bit lv, fz;
      post_e = (post_in == 0) ? 1 : post_in;
      pre_e  = (pre_in + post_e > 1024) ? 1024 - post_e : pre_in;
      t = -1; hit = 0; ovr = 0;
      for (int i = pre_e; i < stim.size() && t < 0; i++) begin
         lv = (i > 0) && ((stim[i-1] & 'hFFF) < lvl) && ((stim[i] & 'hFFF) >= lvl);
         fz = AUTO && (i - pre_e + 1 == TMO);
         if (lv || fz) begin t = i; hit = lv; end
      end
      if (t < 0 || t + post_e > stim.size()) $fatal(1, "stimulus has no complete trigger");
      expq.delete();
      for (int j = t - pre_e; j < t + post_e; j++) expq.push_back(stim[j]);
      for (int j = 0; j < t + post_e; j++) if ((stim[j] & 'h1000) != 0) ovr = 1;
   endtask

   task automatic arm_cfg(input int pre, input int post, input int lvl);
      pre_len = AW'(pre); post_len = AW'(post); trig_level = 12'(lvl);
      arm = 1'b1; tick(); arm = 1'b0;
   endtask

   task automatic feed(input int s, input int gap);
      samp_data = DW'(s); samp_valid = 1'b1; tick(); samp_valid = 1'b0;
      repeat (gap - 1) tick();
   endtask

   // Accept m beats of an n-beat record; mode 0 ready=1, 1 toggling, 2 random.
   task automatic collect(input int n, input int m, input int mode, input string tag);
      int beats, cyc;
      bit pv, pr, rdy, v, l;
      logic [DW-1:0] d, pd;
      beats = 0; cyc = 0; pv = 0; pr = 0; pd = '0;
      while (beats < m && cyc < 4 * m + 50) begin
         rdy = (mode == 0) ? 1'b1 : (mode == 1) ? (cyc % 2 == 0) : 1'($urandom_range(0, 1));
         rd_ready = rdy;
         v = rd_valid; d = rd_data; l = rd_last;
         if (pv && !pr) begin
            chk({tag, "_hold_v"}, 32'(v), 32'd1);
            chk({tag, "_hold_d"}, 32'(d), 32'(pd));
         end
         tick();
         if (v && rdy) begin
            chk({tag, "_data"}, 32'(d), 32'(expq[beats]));
            chk({tag, "_last"}, 32'(l), 32'(beats == n - 1));
            beats++;
         end
         pv = v; pr = rdy; pd = d; cyc++;
      end
      rd_ready = 1'b0;
      chk({tag, "_beats"}, 32'(beats), 32'(m));
   endtask

   task automatic run_capture(input int pre, input int post, input int lvl, input int gap,
                              input int mode, input bit poke, input string tag);
      int t, pe, d0;
      bit hit, ovr;
      model(pre, post, lvl, t, pe, hit, ovr);
      d0 = done_cnt;
      arm_cfg(pre, post, lvl);
      chk({tag, "_busy_arm"}, 32'(busy), 32'd1);
      chk({tag, "_trig_clr"}, 32'(triggered), 32'd0);
      for (int i = 0; i < t + pe; i++) begin
         feed(stim[i], gap);
         if (poke && i == 0) begin
            pre_len = AW'($urandom); post_len = AW'($urandom); trig_level = 12'($urandom);
            arm = 1'b1; tick(); arm = 1'b0;
         end
      end
      repeat (2) tick();
      for (int i = 0; i < 3; i++) feed(int'($urandom_range(0, 8191)), 1);
      chk({tag, "_done"}, 32'(done_cnt - d0), 32'd1);
      chk({tag, "_triggered"}, 32'(triggered), 32'(hit));
      chk({tag, "_ovr"}, 32'(ovr_seen), 32'(ovr));
      chk({tag, "_busy_rd"}, 32'(busy), 32'd1);
      collect(expq.size(), expq.size(), mode, tag);
      chk({tag, "_busy_end"}, 32'(busy), 32'd0);
      chk({tag, "_vld_end"}, 32'(rd_valid), 32'd0);
   endtask

   task automatic gen_rand(input int pre, input int post, input int lvl);
      int n;
      stim.delete();
      n = pre + int'($urandom_range(5, 40));
      for (int i = 0; i < n + post + 2; i++) begin
         if (i == n) stim.push_back(0);
         else if (i == n + 1) stim.push_back(lvl);
         else stim.push_back(int'($urandom_range(0, 4095)) |
                             (($urandom_range(0, 7) == 0) ? 'h1000 : 0));
      end
   endtask

   initial begin
      int t, pe, d0, n, w;
      bit hit, ovr;
      int pre, post, lvl;

      repeat (3) tick();
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_trig", 32'(triggered), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_ovr", 32'(ovr_seen), 32'd0);
      chk("rst_vld", 32'(rd_valid), 32'd0);
      chk("rst_last", 32'(rd_last), 32'd0);
      chk("rst_data", 32'(rd_data), 32'd0);
      rst = 1'b0;
      tick();

      stim.delete();
      for (int i = 0; i < 12; i++) stim.push_back('h7F8 + i);
      run_capture(4, 4, 'h800, 4, 0, 1'b0, "ramp");
      run_capture(4, 4, 'h800, 4, 1, 1'b0, "ramp_stall");

      stim.delete();
      stim.push_back('h050); stim.push_back('h150);
      run_capture(0, 1, 'h100, 2, 0, 1'b0, "single");

      stim.delete();
      for (int i = 0; i < 1124; i++) stim.push_back(i % 4096);
      run_capture(1000, 100, 'h400, 1, 2, 1'b0, "clamp");

      // abort while collecting post-trigger samples
      stim.delete();
      stim.push_back('h100); stim.push_back('h1100); stim.push_back('h100);
      for (int i = 0; i < 8; i++) stim.push_back('h900 + i);
      d0 = done_cnt;
      arm_cfg(2, 8, 'h800);
      for (int i = 0; i < 6; i++) feed(stim[i], 2);
      abort = 1'b1; tick(); abort = 1'b0;
      chk("abpost_busy", 32'(busy), 32'd0);
      chk("abpost_vld", 32'(rd_valid), 32'd0);
      chk("abpost_trig", 32'(triggered), 32'd1);
      chk("abpost_ovr", 32'(ovr_seen), 32'd1);
      feed('h900, 1);
      chk("abpost_done", 32'(done_cnt - d0), 32'd0);

      gen_rand(5, 6, 'h600);
      run_capture(5, 6, 'h600, 1, 0, 1'b0, "after_abort");

      // abort on the cycle of the last handshake
      gen_rand(3, 5, 'h300);
      model(3, 5, 'h300, t, pe, hit, ovr);
      n = expq.size();
      arm_cfg(3, 5, 'h300);
      for (int i = 0; i < t + pe; i++) feed(stim[i], 1);
      collect(n, n - 1, 0, "ablast");
      w = 0;
      while (!rd_valid && w < 10) begin tick(); w++; end
      chk("ablast_vld", 32'(rd_valid), 32'd1);
      chk("ablast_lastflag", 32'(rd_last), 32'd1);
      chk("ablast_lastdata", 32'(rd_data), 32'(expq[n-1]));
      rd_ready = 1'b1; abort = 1'b1; tick(); abort = 1'b0; rd_ready = 1'b0;
      chk("ablast_busy", 32'(busy), 32'd0);
      chk("ablast_vld0", 32'(rd_valid), 32'd0);
      chk("ablast_last0", 32'(rd_last), 32'd0);
      chk("ablast_trig", 32'(triggered), 32'(hit));
      tick();
      chk("ablast_vld1", 32'(rd_valid), 32'd0);

      for (int k = 0; k < 6; k++) begin
         pre  = int'($urandom_range(0, 30));
         post = int'($urandom_range(0, 30));
         lvl  = int'($urandom_range(1, 4095));
         gen_rand(pre, post, lvl);
         run_capture(pre, post, lvl, int'($urandom_range(1, 3)), 2, 1'b1, $sformatf("rnd%0d", k));
      end

      // asynchronous reset mid-capture
      stim.delete();
      for (int i = 0; i < 20; i++) stim.push_back((i < 4) ? 'h010 : 'h1F00);
      arm_cfg(2, 10, 'h800);
      for (int i = 0; i < 6; i++) feed(stim[i], 1);
      chk("rstmid_trig_pre", 32'(triggered), 32'd1);
      rst = 1'b1; #1;
      chk("rstmid_busy", 32'(busy), 32'd0);
      chk("rstmid_trig", 32'(triggered), 32'd0);
      chk("rstmid_ovr", 32'(ovr_seen), 32'd0);
      chk("rstmid_vld", 32'(rd_valid), 32'd0);
      tick(); rst = 1'b0; tick();

      gen_rand(7, 3, 'hA00);
      run_capture(7, 3, 'hA00, 1, 1, 1'b0, "after_rst");

`ifdef ADC_CAP_AUTOTRIG_EN
      stim.delete();
      for (int i = 0; i < 2 + TMO + 3; i++) stim.push_back((i == 5) ? 'h1000 : 0);
      run_capture(2, 3, 'h800, 1, 0, 1'b0, "autotrig");
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
